seg7_scan_mux: RTL and testbench

Time-multiplexed driver for a bank of common-anode 7-segment digits. It takes a packed BCD/hex value plus per-digit decimal points and latches them through a tear-free double buffer that updates only at frame boundaries. It scans one digit at a time with a programmable refresh period and a dead cycle between digits. It replaces per-digit static decoders at the display edge of the calculator datapath, with leading-zero blanking and hex mode.

---
 rtl/seg7_scan_mux_if.sv | 26 ++
 rtl/seg7_scan_mux.sv | 146 ++++++++++++++
 tb/tb_seg7_scan_mux.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_mux_if.sv
// Host/display bundle for the 7-segment scan multiplexer.
// The host writes data and controls; the display side returns segment and anode drives.
interface seg7_scan_mux_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lzb;
  logic                      en;
  logic [6:0]                seg_n;
  logic                      dp_n;
  logic [NUM_DIGITS-1:0]     an_n;
  logic                      pending;
  logic                      frame_tick;

  modport master (
    output load, digits_in, dp_in, lzb, en,
    input  seg_n, dp_n, an_n, pending, frame_tick
  );

  modport slave (
    input  load, digits_in, dp_in, lzb, en,
    output seg_n, dp_n, an_n, pending, frame_tick
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with a frame-synchronous
// double buffer, leading-zero blanking and optional hex glyphs.
module seg7_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned HEX_MODE    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  seg7_scan_mux_if.slave  bus
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  digits_t               pbuf_q, pbuf_d;
  logic [NUM_DIGITS-1:0] pdp_q, pdp_d;
  digits_t               shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] sdp_q, sdp_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  tick_q, tick_d;

  logic                  term_c, last_c, bnd_c;
  logic                  zero_run_c;
  logic [NUM_DIGITS-1:0] blank_c;

  // Active-low {g,f,e,d,c,b,a}; codes above 9 go dark unless hex glyphs are enabled.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    if ((v > 4'h9) && (HEX_MODE == 0)) s = 7'h7F;
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      pbuf_q   <= '0;
      pdp_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      pend_q   <= 1'b0;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      an_q     <= '1;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pbuf_q   <= pbuf_d;
      pdp_q    <= pdp_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pbuf_d     = pbuf_q;
    pdp_d      = pdp_q;
    shadow_d   = shadow_q;
    sdp_d      = sdp_q;
    pend_d     = pend_q;
    seg_d      = 7'h7F;
    dp_d       = 1'b1;
    an_d       = '1;
    zero_run_c = 1'b1;
    blank_c    = '0;

    term_c = (cnt_q == CW'(REFRESH_DIV - 1));
    last_c = (idx_q == IW'(NUM_DIGITS - 1));
    bnd_c  = term_c && last_c;
    tick_d = bnd_c;

    cnt_d = term_c ? '0 : cnt_q + CW'(1);
    if (term_c) idx_d = last_c ? '0 : idx_q + IW'(1);

    if (bus.load) begin
      pbuf_d = bus.digits_in;
      pdp_d  = bus.dp_in;
      pend_d = 1'b1;
    end

    // A load on the boundary bypasses the pending stage and lands in the next frame.
    if (bnd_c) begin
      pend_d = 1'b0;
      if (bus.load) begin
        shadow_d = bus.digits_in;
        sdp_d    = bus.dp_in;
      end else if (pend_q) begin
        shadow_d = pbuf_q;
        sdp_d    = pdp_q;
      end
    end

    // Blank the run of zeros from the top digit down; digit 0 always shows.
    for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
      zero_run_c = zero_run_c && (shadow_q[k] == 4'h0);
      blank_c[k] = bus.lzb && zero_run_c;
    end

    if (bus.en && (cnt_q != '0)) begin
      an_d[idx_q] = 1'b0;
      seg_d       = blank_c[idx_q] ? 7'h7F : decode(shadow_q[idx_q]);
      dp_d        = ~sdp_q[idx_q];
    end
  end

  assign bus.seg_n      = seg_q;
  assign bus.dp_n       = dp_q;
  assign bus.an_n       = an_q;
  assign bus.pending    = pend_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: two instances (decimal-only and hex glyphs) driven in
// lockstep and compared every cycle against a time-indexed reference model.
module tb_seg7_scan_mux;

  localparam int N = 4;
  localparam int R = 4;
  localparam int F = N * R;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic        lzb;
  logic        en;
  logic [15:0] din;
  logic [3:0]  dpin;

  int total;
  int bad;

  // Reference model: time since reset release plus the two buffers.
  int          t;
  logic [15:0] sh_v;
  logic [3:0]  shdp;
  logic [15:0] pb;
  logic [3:0]  pbdp;
  bit          pend;

  logic [6:0] e_seg0, e_seg1;
  logic [3:0] e_an;
  logic       e_dp;
  logic       e_ft;
  logic       e_pend;
  logic [6:0] seg_tab [16];

  seg7_scan_mux_if #(.NUM_DIGITS(N)) b0 ();
  seg7_scan_mux_if #(.NUM_DIGITS(N)) b1 ();

  assign b0.load = load;  assign b0.digits_in = din;  assign b0.dp_in = dpin;
  assign b0.lzb  = lzb;   assign b0.en        = en;
  assign b1.load = load;  assign b1.digits_in = din;  assign b1.dp_in = dpin;
  assign b1.lzb  = lzb;   assign b1.en        = en;

  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(0)) u_dec (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  seg7_scan_mux #(.NUM_DIGITS(N), .REFRESH_DIV(R), .HEX_MODE(1)) u_hex (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] v, input bit hex);
    if (v > 4'h9 && !hex) return 7'h7F;
    return seg_tab[v];
  endfunction

  task automatic chk_reset();
    chk("rst_seg0", 32'(b0.seg_n), 32'h7F);
    chk("rst_seg1", 32'(b1.seg_n), 32'h7F);
    chk("rst_an",   32'(b0.an_n),  32'hF);
    chk("rst_dp",   32'(b0.dp_n),  32'h1);
    chk("rst_pend", 32'(b0.pending), 32'h0);
    chk("rst_ft",   32'(b1.frame_tick), 32'h0);
  endtask

  task automatic model_reset();
    t = 0; sh_v = '0; shdp = '0; pb = '0; pbdp = '0; pend = 1'b0;
  endtask

  // Predict the outputs produced by this clock edge, advance the model, then compare.
  task automatic tick();
    int          cnt;
    int          idx;
    bit          bnd;
    bit          blank;
    logic [15:0] v;
    cnt = t % R;
    idx = (t / R) % N;
    bnd = (t % F) == F - 1;
    e_an = 4'hF; e_seg0 = 7'h7F; e_seg1 = 7'h7F; e_dp = 1'b1;
    if (en && cnt != 0) begin
      v     = sh_v >> (4 * idx);
      blank = lzb && idx > 0 && v == 16'h0;
      e_an[idx] = 1'b0;
      e_seg0 = blank ? 7'h7F : glyph(v[3:0], 1'b0);
      e_seg1 = blank ? 7'h7F : glyph(v[3:0], 1'b1);
      e_dp   = ~shdp[idx];
    end
    e_ft = bnd;
    if (bnd) begin
      if (load) begin sh_v = din; shdp = dpin; end
      else if (pend) begin sh_v = pb; shdp = pbdp; end
      pend = 1'b0;
    end else if (load) begin
      pb = din; pbdp = dpin; pend = 1'b1;
    end
    e_pend = pend;
    t++;
    @(posedge clk);
    #1;
    chk("seg_dec", 32'(b0.seg_n), 32'(e_seg0));
    chk("seg_hex", 32'(b1.seg_n), 32'(e_seg1));
    chk("an",      32'(b0.an_n),  32'(e_an));
    chk("an_hex",  32'(b1.an_n),  32'(e_an));
    chk("dp",      32'(b0.dp_n),  32'(e_dp));
    chk("pending", 32'(b0.pending), 32'(e_pend));
    chk("ftick",   32'(b0.frame_tick), 32'(e_ft));
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < F; i++) begin
      if (t % F == phase) break;
      tick();
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    din = d; dpin = p; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    chk_reset();
    model_reset();
    @(posedge clk);
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rv;
    total = 0; bad = 0;
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    rst_n = 1'b0; load = 1'b0; din = '0; dpin = '0; lzb = 1'b0; en = 1'b1;
    model_reset();

    #12;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset();

    run(36);

    // Mid-frame load held until the boundary.
    run_to(5);
    do_load(16'h1234, 4'b0100);
    run(40);

    // Two loads in one frame: last write wins; then blanking.
    run_to(2);
    do_load(16'h0007, 4'b0000);
    run(3);
    do_load(16'h0042, 4'b0000);
    run(35);
    lzb = 1'b1;
    run(32);

    do_load(16'h0000, 4'b0010);
    run(40);
    do_load(16'hABCD, 4'b0000);
    run(40);
    lzb = 1'b0;

    // Load on the boundary cycle, then one disabled frame.
    run_to(F - 1);
    do_load(16'h5678, 4'b1001);
    run(20);
    run_to(0);
    en = 1'b0;
    run(F);
    en = 1'b1;
    run(20);

    // Reset while data is pending: it must never surface.
    run_to(3);
    do_load(16'h9999, 4'b1111);
    run(2);
    mid_reset();
    run(40);

    // Random traffic with zero-biased digits.
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 31) == 0) lzb = ~lzb;
      if ($urandom_range(0, 47) == 0) en = ~en;
      if ($urandom_range(0, 6) == 0) begin
        rv = 16'($urandom);
        for (int k = 0; k < N; k++)
          if ($urandom_range(0, 1) == 0) rv[4*k +: 4] = 4'h0;
        din = rv; dpin = 4'($urandom); load = 1'b1;
      end
      tick();
      load = 1'b0;
      if (c == 450) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
